// File: rtl/raytrace_pkg.sv
// Shared types and default sizing for the ray dispatch scheduler and its raster counter.
package raytrace_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DISPATCH = 2'd1,
        DRAIN    = 2'd2
    } sched_state_t;

    localparam int DEFAULT_MAX_CORES = 2;
    localparam int DEFAULT_COORD_W   = 13;

endpackage

// File: rtl/pixel_coord_counter.sv
// Raster x/y counter. Frame dimensions are captured on clear; restart rewinds to (0,0)
// and keeps them. Tag outputs are registered alongside the coordinates.
module pixel_coord_counter
    import raytrace_pkg::*;
#(
    parameter int COORD_W = DEFAULT_COORD_W
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               clear_i,
    input  logic               restart_i,
    input  logic               advance_i,
    input  logic [COORD_W-1:0] width_i,
    input  logic [COORD_W-1:0] height_i,
    output logic [COORD_W-1:0] x_o,
    output logic [COORD_W-1:0] y_o,
    output logic               sof_o,
    output logic               eol_o,
    output logic               last_o
);

    logic [COORD_W-1:0] w_q, w_d, h_q, h_d, x_q, x_d, y_q, y_d;
    logic               sof_q, sof_d, eol_q, eol_d, last_q, last_d;

    always_comb begin
        w_d = w_q;
        h_d = h_q;
        x_d = x_q;
        y_d = y_q;
        if (clear_i) begin
            w_d = width_i;
            h_d = height_i;
            x_d = '0;
            y_d = '0;
        end else if (restart_i) begin
            x_d = '0;
            y_d = '0;
        end else if (advance_i) begin
            if (x_q == w_q - COORD_W'(1)) begin
                x_d = '0;
                y_d = y_q + COORD_W'(1);
            end else begin
                x_d = x_q + COORD_W'(1);
            end
        end
        // Tags are derived from the next position so they line up with the registered x/y.
        sof_d  = (x_d == '0) && (y_d == '0);
        eol_d  = (x_d == w_d - COORD_W'(1));
        last_d = eol_d && (y_d == h_d - COORD_W'(1));
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            w_q    <= '0;
            h_q    <= '0;
            x_q    <= '0;
            y_q    <= '0;
            sof_q  <= 1'b0;
            eol_q  <= 1'b0;
            last_q <= 1'b0;
        end else begin
            w_q    <= w_d;
            h_q    <= h_d;
            x_q    <= x_d;
            y_q    <= y_d;
            sof_q  <= sof_d;
            eol_q  <= eol_d;
            last_q <= last_d;
        end
    end

    assign x_o    = x_q;
    assign y_o    = y_q;
    assign sof_o  = sof_q;
    assign eol_o  = eol_q;
    assign last_o = last_q;

endmodule

// File: rtl/ray_dispatch_scheduler.sv
// Round-robin pixel dispatcher with retire counting and frame completion.
// Define SCHED_FRAME_LOOP_EN to run frames back-to-back until start is seen in DRAIN.
module ray_dispatch_scheduler
    import raytrace_pkg::*;
#(
    parameter int MAX_CORES = DEFAULT_MAX_CORES,
    parameter int COORD_W   = DEFAULT_COORD_W
) (
    input  logic                 aclk,
    input  logic                 aresetn,
    input  logic                 start,
    input  logic [COORD_W-1:0]   image_width,
    input  logic [COORD_W-1:0]   image_height,
    input  logic [1:0]           no_of_extra_cores,
    output logic [MAX_CORES-1:0] req_valid,
    input  logic [MAX_CORES-1:0] req_ready,
    output logic [COORD_W-1:0]   req_x,
    output logic [COORD_W-1:0]   req_y,
    output logic                 req_sof,
    output logic                 req_eol,
    input  logic                 pix_retired,
    output logic                 busy,
    output logic                 frame_done
);

    localparam int CUR_W = (MAX_CORES > 1) ? $clog2(MAX_CORES) : 1;
    localparam int CNT_W = 2 * COORD_W;

    sched_state_t         state_q, state_d;
    logic [CUR_W-1:0]     cur_q, cur_d, last_core_q, last_core_d;
    logic [CNT_W-1:0]     total_q, total_d, cnt_q, cnt_d;
    logic [MAX_CORES-1:0] req_valid_q, req_valid_d;
    logic                 busy_q, done_q, done_d;
    logic                 hs, ctr_clear, ctr_restart, ctr_last;
    int                   ext_cores;
`ifdef SCHED_FRAME_LOOP_EN
    logic                 stop_q, stop_d;
`endif

    // req_valid_q is one-hot on cur_q, so this is the handshake of the selected core only.
    assign hs = |(req_valid_q & req_ready);

    pixel_coord_counter #(.COORD_W(COORD_W)) u_coord (
        .clk_i     (aclk),
        .rst_ni    (aresetn),
        .clear_i   (ctr_clear),
        .restart_i (ctr_restart),
        .advance_i (hs),
        .width_i   (image_width),
        .height_i  (image_height),
        .x_o       (req_x),
        .y_o       (req_y),
        .sof_o     (req_sof),
        .eol_o     (req_eol),
        .last_o    (ctr_last)
    );

    always_comb begin
        state_d     = state_q;
        cur_d       = cur_q;
        last_core_d = last_core_q;
        total_d     = total_q;
        cnt_d       = cnt_q;
        done_d      = 1'b0;
        ctr_clear   = 1'b0;
        ctr_restart = 1'b0;
        ext_cores   = int'(no_of_extra_cores);
        if (ext_cores > MAX_CORES - 1) ext_cores = MAX_CORES - 1;
`ifdef SCHED_FRAME_LOOP_EN
        stop_d      = stop_q;
`endif
        if (state_q != IDLE && pix_retired) cnt_d = cnt_q + CNT_W'(1);

        case (state_q)
            IDLE: begin
                if (start && image_width != '0 && image_height != '0) begin
                    state_d     = DISPATCH;
                    cur_d       = '0;
                    last_core_d = CUR_W'(ext_cores);
                    total_d     = CNT_W'(image_width) * CNT_W'(image_height);
                    cnt_d       = '0;
                    ctr_clear   = 1'b1;
`ifdef SCHED_FRAME_LOOP_EN
                    stop_d      = 1'b0;
`endif
                end
            end
            DISPATCH: begin
                if (hs) begin
                    cur_d = (cur_q == last_core_q) ? '0 : cur_q + CUR_W'(1);
                    if (ctr_last) state_d = DRAIN;
                end
            end
            DRAIN: begin
`ifdef SCHED_FRAME_LOOP_EN
                if (start) stop_d = 1'b1;
`endif
                // >= also covers retires that arrived early while still dispatching.
                if (cnt_d >= total_q) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
`ifdef SCHED_FRAME_LOOP_EN
                    if (!(stop_q || start)) begin
                        state_d     = DISPATCH;
                        cur_d       = '0;
                        cnt_d       = '0;
                        ctr_restart = 1'b1;
                    end
`endif
                end
            end
            default: state_d = IDLE;
        endcase

        req_valid_d = '0;
        if (state_d == DISPATCH) req_valid_d[cur_d] = 1'b1;
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q     <= IDLE;
            cur_q       <= '0;
            last_core_q <= '0;
            total_q     <= '0;
            cnt_q       <= '0;
            req_valid_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
`ifdef SCHED_FRAME_LOOP_EN
            stop_q      <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cur_q       <= cur_d;
            last_core_q <= last_core_d;
            total_q     <= total_d;
            cnt_q       <= cnt_d;
            req_valid_q <= req_valid_d;
            busy_q      <= (state_d != IDLE);
            done_q      <= done_d;
`ifdef SCHED_FRAME_LOOP_EN
            stop_q      <= stop_d;
`endif
        end
    end

    assign req_valid  = req_valid_q;
    assign busy       = busy_q;
    assign frame_done = done_q;

endmodule

// File: tb/tb_ray_dispatch_scheduler.sv
// Directed, table-driven bench for ray_dispatch_scheduler (both SCHED_FRAME_LOOP_EN builds).
module tb_ray_dispatch_scheduler;

    localparam int MC = 2;
    localparam int CW = 13;

    logic          aclk = 1'b0;
    logic          aresetn, start, pix_retired;
    logic [CW-1:0] image_width, image_height;
    logic [1:0]    no_of_extra_cores;
    logic [MC-1:0] req_valid, req_ready;
    logic [CW-1:0] req_x, req_y;
    logic          req_sof, req_eol, busy, frame_done;

    int n_cmp = 0;
    int n_err = 0;

    always #5 aclk = ~aclk;

    ray_dispatch_scheduler #(.MAX_CORES(MC), .COORD_W(CW)) dut (
        .aclk              (aclk),
        .aresetn           (aresetn),
        .start             (start),
        .image_width       (image_width),
        .image_height      (image_height),
        .no_of_extra_cores (no_of_extra_cores),
        .req_valid         (req_valid),
        .req_ready         (req_ready),
        .req_x             (req_x),
        .req_y             (req_y),
        .req_sof           (req_sof),
        .req_eol           (req_eol),
        .pix_retired       (pix_retired),
        .busy              (busy),
        .frame_done        (frame_done)
    );

    typedef struct {
        logic          rstn, start;
        logic [CW-1:0] w, h;
        logic [1:0]    ext, rdy;
        logic          ret;
        logic [1:0]    ev;
        logic [CW-1:0] ex, ey;
        logic          es, ee, eb, ed;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t v(input logic rstn, input logic st, input int w, input int h,
                               input int ext, input int rdy, input logic ret, input int ev,
                               input int ex, input int ey, input logic es, input logic ee,
                               input logic eb, input logic ed);
        vec_t r;
        r.rstn = rstn; r.start = st; r.w = CW'(w); r.h = CW'(h);
        r.ext = 2'(ext); r.rdy = 2'(rdy); r.ret = ret; r.ev = 2'(ev);
        r.ex = CW'(ex); r.ey = CW'(ey); r.es = es; r.ee = ee; r.eb = eb; r.ed = ed;
        return r;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic run_table();
        for (int i = 0; i < tbl.size(); i++) begin
            aresetn           = tbl[i].rstn;
            start             = tbl[i].start;
            image_width       = tbl[i].w;
            image_height      = tbl[i].h;
            no_of_extra_cores = tbl[i].ext;
            req_ready         = tbl[i].rdy;
            pix_retired       = tbl[i].ret;
            @(negedge aclk);
            chk($sformatf("row%0d_valid", i), int'(req_valid), int'(tbl[i].ev));
            chk($sformatf("row%0d_busy", i), int'(busy), int'(tbl[i].eb));
            chk($sformatf("row%0d_done", i), int'(frame_done), int'(tbl[i].ed));
            if (tbl[i].ev != 2'b00) begin
                chk($sformatf("row%0d_x", i), int'(req_x), int'(tbl[i].ex));
                chk($sformatf("row%0d_y", i), int'(req_y), int'(tbl[i].ey));
                chk($sformatf("row%0d_sof", i), int'(req_sof), int'(tbl[i].es));
                chk($sformatf("row%0d_eol", i), int'(req_eol), int'(tbl[i].ee));
            end
            @(posedge aclk); #1;
        end
    endtask

    initial begin
        aresetn = 1'b0; start = 1'b0; pix_retired = 1'b0;
        image_width = '0; image_height = '0; no_of_extra_cores = '0; req_ready = '0;
        @(posedge aclk); #1;
        @(negedge aclk);
        chk("rst_x", int'(req_x), 0);
        chk("rst_y", int'(req_y), 0);
        chk("rst_sof", int'(req_sof), 0);
        chk("rst_eol", int'(req_eol), 0);
        @(posedge aclk); #1;

        tbl.push_back(v(0,0,4,2,1,3,0, 0,0,0,0,0,0,0));
`ifndef SCHED_FRAME_LOOP_EN
        // 4x2 frame on two cores, start mid-frame is ignored
        tbl.push_back(v(1,1,4,2,1,3,0, 0,0,0,0,0,0,0));
        tbl.push_back(v(1,0,4,2,1,3,0, 1,0,0,1,0,1,0));
        tbl.push_back(v(1,0,4,2,1,3,0, 2,1,0,0,0,1,0));
        tbl.push_back(v(1,0,4,2,1,3,1, 1,2,0,0,0,1,0));
        tbl.push_back(v(1,0,4,2,1,3,1, 2,3,0,0,1,1,0));
        tbl.push_back(v(1,1,4,2,1,3,1, 1,0,1,0,0,1,0));
        tbl.push_back(v(1,0,4,2,1,3,1, 2,1,1,0,0,1,0));
        tbl.push_back(v(1,0,4,2,1,3,1, 1,2,1,0,0,1,0));
        tbl.push_back(v(1,0,4,2,1,3,1, 2,3,1,0,1,1,0));
        tbl.push_back(v(1,0,4,2,1,3,1, 0,0,0,0,0,1,0));
        tbl.push_back(v(1,0,4,2,1,3,1, 0,0,0,0,0,1,0));
        tbl.push_back(v(1,0,4,2,1,3,0, 0,0,0,0,0,0,1));
        tbl.push_back(v(1,0,4,2,1,3,0, 0,0,0,0,0,0,0));
        // core 1 stalls for five cycles, then reset at pixel 3 and restart
        tbl.push_back(v(1,1,4,2,1,3,0, 0,0,0,0,0,0,0));
        tbl.push_back(v(1,0,4,2,1,1,0, 1,0,0,1,0,1,0));
        for (int k = 0; k < 5; k++) tbl.push_back(v(1,0,4,2,1,1,0, 2,1,0,0,0,1,0));
        tbl.push_back(v(1,0,4,2,1,3,0, 2,1,0,0,0,1,0));
        tbl.push_back(v(0,0,4,2,1,0,0, 1,2,0,0,0,1,0));
        tbl.push_back(v(1,0,4,2,1,3,0, 0,0,0,0,0,0,0));
        tbl.push_back(v(1,1,4,2,1,3,0, 0,0,0,0,0,0,0));
        tbl.push_back(v(1,0,4,2,1,0,0, 1,0,0,1,0,1,0));
        tbl.push_back(v(0,0,4,2,1,0,0, 1,0,0,1,0,1,0));
        tbl.push_back(v(1,0,4,2,1,0,0, 0,0,0,0,0,0,0));
        // single active core, 2x2
        tbl.push_back(v(1,1,2,2,0,3,0, 0,0,0,0,0,0,0));
        tbl.push_back(v(1,0,2,2,0,3,0, 1,0,0,1,0,1,0));
        tbl.push_back(v(1,0,2,2,0,3,1, 1,1,0,0,1,1,0));
        tbl.push_back(v(1,0,2,2,0,3,1, 1,0,1,0,0,1,0));
        tbl.push_back(v(1,0,2,2,0,3,1, 1,1,1,0,1,1,0));
        tbl.push_back(v(1,0,2,2,0,3,1, 0,0,0,0,0,1,0));
        tbl.push_back(v(1,0,2,2,0,3,0, 0,0,0,0,0,0,1));
        // extra cores = 3 clamps to two cores, 3x1
        tbl.push_back(v(1,1,3,1,3,3,0, 0,0,0,0,0,0,0));
        tbl.push_back(v(1,0,3,1,3,3,0, 1,0,0,1,0,1,0));
        tbl.push_back(v(1,0,3,1,3,3,0, 2,1,0,0,0,1,0));
        tbl.push_back(v(1,0,3,1,3,3,0, 1,2,0,0,1,1,0));
        tbl.push_back(v(1,0,3,1,3,3,1, 0,0,0,0,0,1,0));
        tbl.push_back(v(1,0,3,1,3,3,1, 0,0,0,0,0,1,0));
        tbl.push_back(v(1,0,3,1,3,3,1, 0,0,0,0,0,1,0));
        tbl.push_back(v(1,0,3,1,3,3,0, 0,0,0,0,0,0,1));
        // 1x1 frame
        tbl.push_back(v(1,1,1,1,0,3,0, 0,0,0,0,0,0,0));
        tbl.push_back(v(1,0,1,1,0,3,0, 1,0,0,1,1,1,0));
        tbl.push_back(v(1,0,1,1,0,3,1, 0,0,0,0,0,1,0));
        tbl.push_back(v(1,0,1,1,0,3,0, 0,0,0,0,0,0,1));
        // zero dimensions ignored, retires in IDLE ignored
        tbl.push_back(v(1,1,0,5,0,3,1, 0,0,0,0,0,0,0));
        tbl.push_back(v(1,0,0,5,0,3,1, 0,0,0,0,0,0,0));
        tbl.push_back(v(1,1,5,0,0,3,1, 0,0,0,0,0,0,0));
        tbl.push_back(v(1,0,5,0,0,3,1, 0,0,0,0,0,0,0));
        tbl.push_back(v(1,1,1,1,0,3,0, 0,0,0,0,0,0,0));
        tbl.push_back(v(1,0,1,1,0,3,0, 1,0,0,1,1,1,0));
        tbl.push_back(v(1,0,1,1,0,3,0, 0,0,0,0,0,1,0));
        tbl.push_back(v(1,0,1,1,0,3,1, 0,0,0,0,0,1,0));
        tbl.push_back(v(1,0,1,1,0,3,0, 0,0,0,0,0,0,1));
`else
        // 2x1 frames loop; start in DRAIN ends after the current frame
        tbl.push_back(v(1,1,2,1,1,3,0, 0,0,0,0,0,0,0));
        tbl.push_back(v(1,0,2,1,1,3,0, 1,0,0,1,0,1,0));
        tbl.push_back(v(1,0,2,1,1,3,0, 2,1,0,0,1,1,0));
        tbl.push_back(v(1,0,2,1,1,3,1, 0,0,0,0,0,1,0));
        tbl.push_back(v(1,0,2,1,1,3,1, 0,0,0,0,0,1,0));
        tbl.push_back(v(1,0,2,1,1,3,0, 1,0,0,1,0,1,1));
        tbl.push_back(v(1,0,2,1,1,3,0, 2,1,0,0,1,1,0));
        tbl.push_back(v(1,1,2,1,1,3,1, 0,0,0,0,0,1,0));
        tbl.push_back(v(1,0,2,1,1,3,1, 0,0,0,0,0,1,0));
        tbl.push_back(v(1,0,2,1,1,3,0, 0,0,0,0,0,0,1));
        tbl.push_back(v(1,0,2,1,1,3,0, 0,0,0,0,0,0,0));
`endif
        run_table();

`ifndef SCHED_FRAME_LOOP_EN
        begin : seq_irregular_ready
            int hs_n, mx, my, core;
            hs_n = 0; mx = 0; my = 0; core = 0;
            aresetn = 1'b1; pix_retired = 1'b0; req_ready = 2'b00;
            image_width = CW'(4); image_height = CW'(2); no_of_extra_cores = 2'd1;
            start = 1'b1;
            @(posedge aclk); #1;
            start = 1'b0;
            for (int c = 0; c < 100 && hs_n < 8; c++) begin
                req_ready = (c % 3 == 2) ? 2'b00 : 2'b11;
                @(negedge aclk);
                chk($sformatf("seq_valid_c%0d", c), int'(req_valid), 1 << core);
                chk($sformatf("seq_x_c%0d", c), int'(req_x), mx);
                chk($sformatf("seq_y_c%0d", c), int'(req_y), my);
                if (req_ready[core]) begin
                    hs_n++;
                    core = 1 - core;
                    if (mx == 3) begin mx = 0; my++; end
                    else mx++;
                end
                @(posedge aclk); #1;
            end
            chk("seq_hs_count", hs_n, 8);
            @(negedge aclk);
            chk("seq_drain_valid", int'(req_valid), 0);
            chk("seq_drain_busy", int'(busy), 1);
            @(posedge aclk); #1;
            for (int k = 0; k < 8; k++) begin
                pix_retired = 1'b1;
                @(negedge aclk);
                chk($sformatf("seq_nodone_%0d", k), int'(frame_done), 0);
                @(posedge aclk); #1;
            end
            pix_retired = 1'b0;
            @(negedge aclk);
            chk("seq_done", int'(frame_done), 1);
            chk("seq_idle_busy", int'(busy), 0);
            @(posedge aclk); #1;
            @(negedge aclk);
            chk("seq_done_pulse", int'(frame_done), 0);
        end
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
